// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES
// registered SEG-bit lookahead groups with a valid/ready handshake.
`timescale 1ns/1ps
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int SEG = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be at least 2");
    end

    logic             advance;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic [SEG+1:0]   seg_r [STAGES];

    // Every carry is a flat sum of generate terms, not a ripple chain.
    function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] g,
                                                 input logic [SEG-1:0] p,
                                                 input logic cin);
        logic [SEG:0] c;
        logic         prop;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = 1'b0;
            prop   = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & prop);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & cin);
        end
        return c;
    endfunction

    // Returns {carry out, carry into group MSB, sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic cin);
        logic [SEG:0] c;
        c = cla_carries(a & b, a | b, cin);
        return {c[SEG], c[SEG-1], a ^ b ^ c[SEG-1:0]};
    endfunction

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_r[k] = seg_add(a_q[k][k*SEG +: SEG], b_q[k][k*SEG +: SEG], c_q[k]);
            s_nx[k]  = s_q[k];
            s_nx[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
        end
    end

    // Data registers load only behind a valid slot so bubbles never toggle them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (advance) begin
            v_q[0] <= i_valid;
            if (i_valid) begin
                a_q[0] <= i_add1;
                b_q[0] <= i_sub ? ~i_add2 : i_add2;
                c_q[0] <= i_sub | i_carry;
                s_q[0] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
                    c_q[k] <= seg_r[k-1][SEG+1];
                    s_q[k] <= s_nx[k-1];
                end
            end
            o_valid <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                o_result   <= s_nx[STAGES-1];
                o_carry    <= seg_r[STAGES-1][SEG+1];
                o_overflow <= seg_r[STAGES-1][SEG+1] ^ seg_r[STAGES-1][SEG];
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the single-cycle combinational carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into STAGES registered segments. Each segment is a SEG-bit carry-lookahead group, and the inter-segment carry is registered.
- Adds a carry-in, a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the datapath wherever a wide add must close timing at full clock rate.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline segments; must divide WIDTH. SEG = WIDTH/STAGES; STAGES=1 gives a single registered CLA.

Ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept input this cycle.
- i_add1  in  WIDTH  operand A.
- i_add2  in  WIDTH  operand B.
- i_carry  in  1  carry-in; ignored when i_sub=1.
- i_sub  in  1  1 = A − B, 0 = A + B + i_carry.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  WIDTH  sum/difference.
- o_carry  out  1  carry-out of MSB; for subtract, 1 = no borrow.
- o_overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (i_rst_n low, asynchronous): all stage valid bits, data registers, carry registers, o_valid, o_result, o_carry and o_overflow go to 0. o_ready is 1 after release. Reset mid-operation discards all in-flight operations; nothing is emitted for them.
- Operand prep: B' = i_sub ? ~i_add2 : i_add2. cin = i_sub ? 1 : i_carry.
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] per bit:
  - G = A&B', P = A|B'.
  - Group carries via lookahead from the registered carry out of stage k-1 (stage 0 uses cin).
  - Sum bit = A^B'^c.
- Skew: upper operand bits travel in delay registers until their segment is computed. Lower result bits are held in registers until the last stage.
- Latency: an input accepted on edge t appears with o_valid=1 after edge t+STAGES, given no stall.
- Stall: advance = !o_valid | i_ready, and o_ready = advance.
  - When advance=0, every pipeline register holds, including valid bits.
  - Bubbles are not compressed; a held pipeline keeps its internal empty slots.
- Transfer rules: input is taken only when i_valid & o_ready. Output transfers when o_valid & i_ready.
- While stalled, o_result, o_carry and o_overflow are stable.
- Simultaneous output transfer and input accept in the same cycle: both occur; sustained throughput is 1 operation/cycle.
- Overflow: the last stage also registers the carry into bit WIDTH-1 to form o_overflow.
- Wrap-around: results are modulo 2^WIDTH, and the carry is reported on o_carry.
- Data registers are updated only when valid, so invalid slots do not toggle outputs. o_result holds its last value while o_valid=0.
- Parameter check: if WIDTH % STAGES != 0, elaboration fails with a generate-time error.

Test Plan (WIDTH=32, STAGES=4, i_ready=1 unless stated):
1. Carry propagation: add 0xFFFFFFFF + 0x00000001, cin=0 -> after 4 cycles result 0x00000000, carry 1, overflow 0. Carry ripples across all segment registers.
2. Signed overflow: add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carry 0, overflow 1. Add 0x0000FFFF + 0, i_carry=1 -> result 0x00010000, carry 0.
3. Subtract:
   - 5 − 7 -> result 0xFFFFFFFE, carry 0, overflow 0.
   - 0x80000000 − 1 -> result 0x7FFFFFFF, carry 1, overflow 1.
   - 9 − 9 -> result 0, carry 1.
4. Streaming with backpressure:
   - Issue 8 back-to-back ops (k + 3k for k=0..7).
   - Drop i_ready for cycles 5–7.
   - Required: o_ready low exactly while o_valid & !i_ready, outputs held stable during the stall, all 8 results emitted in order with none lost or duplicated.
   - Sustained rate of 1/cycle when unstalled.
5. Reset mid-flight: launch 3 ops, assert i_rst_n low asynchronously between clock edges -> all outputs 0 immediately, no stale o_valid after release, and the next op completes correctly with latency 4.
6. Parameter sweep: WIDTH=8 with STAGES=1, 2, 8, random 1000 add/sub ops each -> results, carry and overflow match a behavioural model; latency equals STAGES.
